// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// The optional signed-overflow output is enabled by defining SERIAL_ADDER_OVF_EN.
package serial_adder_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Carry generation of a full adder: majority of three inputs.
    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    // Sum output of a full adder: odd parity of three inputs.
    function automatic logic par3(input logic x, input logic y, input logic z);
        return x ^ y ^ z;
    endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// Combinational 1-bit full adder used by serial_adder for the per-bit add.
module fa_cell
    import serial_adder_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    // Pure combinational sum/carry; no sequencing lives here.
    always_comb begin
        s  = par3(a, b, ci);
        co = maj3(a, b, ci);
    end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: accepts an operand set, adds one bit per cycle LSB first, holds the result.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf_out.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum_out,
    output logic             c_out
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf_out
`endif
);

    localparam int unsigned      CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

    state_e             state_r;
    state_e             state_nxt_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-1:0]   acc_r;
    logic               carry_r;
    logic [WIDTH-1:0]   sum_out_r;
    logic               c_out_r;
    logic               sum_bit_s;
    logic               carry_nxt_s;
    logic               accept_s;
    logic               last_bit_s;

    assign accept_s   = in_valid && (state_r == ST_IDLE);
    assign last_bit_s = (cnt_r == LAST_BIT);

    // Operand registers shift right so bit i is always presented at position 0.
    fa_cell u_fa_cell (
        .a  (a_r[0]),
        .b  (b_r[0]),
        .ci (carry_r),
        .s  (sum_bit_s),
        .co (carry_nxt_s)
    );

    // State register; reset wins over any handshake on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    state_nxt_s = ST_SHIFT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (last_bit_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Handshake outputs decoded from state only.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_r)
            ST_IDLE: begin
                in_ready  = 1'b1;
                out_valid = 1'b0;
            end
            ST_SHIFT: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
            ST_DONE: begin
                in_ready  = 1'b0;
                out_valid = 1'b1;
            end
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // Datapath: capture on accept, one bit per SHIFT cycle, publish result on the last bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r     <= '0;
            a_r       <= '0;
            b_r       <= '0;
            acc_r     <= '0;
            carry_r   <= 1'b0;
            sum_out_r <= '0;
            c_out_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        a_r     <= a_in;
                        b_r     <= b_in;
                        carry_r <= c_in;
                        cnt_r   <= '0;
                    end else begin
                        cnt_r   <= cnt_r;
                    end
                end
                ST_SHIFT: begin
                    a_r     <= {1'b0, a_r[WIDTH-1:1]};
                    b_r     <= {1'b0, b_r[WIDTH-1:1]};
                    acc_r   <= {sum_bit_s, acc_r[WIDTH-1:1]};
                    carry_r <= carry_nxt_s;
                    cnt_r   <= cnt_r + CNT_ONE;
                    if (last_bit_s) begin
                        sum_out_r <= {sum_bit_s, acc_r[WIDTH-1:1]};
                        c_out_r   <= carry_nxt_s;
                    end else begin
                        sum_out_r <= sum_out_r;
                        c_out_r   <= c_out_r;
                    end
                end
                ST_DONE: begin
                    cnt_r <= cnt_r;
                end
                default: begin
                    cnt_r <= '0;
                end
            endcase
        end
    end

    assign sum_out = sum_out_r;
    assign c_out   = c_out_r;

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_out_r;

    // Signed overflow: carry into the MSB (still in carry_r) differs from carry out of it.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_out_r <= 1'b0;
        end else if ((state_r == ST_SHIFT) && last_bit_s) begin
            ovf_out_r <= carry_r ^ carry_nxt_s;
        end else begin
            ovf_out_r <= ovf_out_r;
        end
    end

    assign ovf_out = ovf_out_r;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed corner cases plus randomized operations
// compared against an arithmetic reference model (ovf_out checked when SERIAL_ADDER_OVF_EN is set).
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         c_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum_out;
    logic         c_out;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf_out;
`endif

    int checks = 0;
    int errors = 0;

    logic [W-1:0] last_sum;
    logic         last_cout;
    logic         last_ovf;

    serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum_out   (sum_out),
        .c_out     (c_out)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf_out   (ovf_out)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain unsigned addition, W+1 bits wide.
    function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        int unsigned total;
        total = int'(a) + int'(b) + int'(ci);
        return total[W:0];
    endfunction

    // Reference: signed result out of the W-bit two's complement range.
    function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        int sv;
        sv = int'($signed(a)) + int'($signed(b)) + int'(ci);
        return (sv > ((2 ** (W - 1)) - 1)) || (sv < -(2 ** (W - 1)));
    endfunction

    task automatic check_held(input string tag);
        check_val({tag, "_sum"}, 32'(sum_out), 32'(last_sum));
        check_val({tag, "_cout"}, 32'(c_out), 32'(last_cout));
`ifdef SERIAL_ADDER_OVF_EN
        check_val({tag, "_ovf"}, 32'(ovf_out), 32'(last_ovf));
`endif
    endtask

    // One full operation: accept, random garbage on inputs while busy, latency, result, hold, release.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci, input int hold);
        logic [W:0] full;
        int         n;
        int         lat;
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_val("ready_before_accept", 32'(in_ready), 32'd1);
        a_in = a; b_in = b; c_in = ci; in_valid = 1'b1;
        out_ready = 1'($urandom);
        @(posedge clk); #1;
        a_in = W'($urandom); b_in = W'($urandom); c_in = 1'($urandom);
        check_val("busy_in_ready", 32'(in_ready), 32'd0);
        check_held("shift_hold");
        lat = 0;
        while (!out_valid && lat < 4 * W) begin
            @(posedge clk); #1;
            lat++;
            a_in = W'($urandom); b_in = W'($urandom);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_val("latency", 32'(lat), 32'(W));
        full = ref_add(a, b, ci);
        last_sum  = full[W-1:0];
        last_cout = full[W];
        last_ovf  = ref_ovf(a, b, ci);
        check_held("result");
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check_val("done_valid", 32'(out_valid), 32'd1);
            check_val("done_in_ready", 32'(in_ready), 32'd0);
            check_held("done_hold");
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_val("release_valid", 32'(out_valid), 32'd0);
        check_val("release_in_ready", 32'(in_ready), 32'd1);
        check_held("idle_hold");
    endtask

    initial begin
        logic [W:0]   full;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        logic [W-1:0] q_sum[$];
        logic         q_cout[$];
        int           prev;
        int           nres;
        logic         saw_valid;

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a_in = '0; b_in = '0; c_in = 1'b0;
        last_sum = '0; last_cout = 1'b0; last_ovf = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check_val("rst_in_ready", 32'(in_ready), 32'd1);
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_held("rst");

        run_op(8'h0F, 8'h01, 1'b0, 1);
        run_op(8'hFF, 8'h01, 1'b0, 0);
        run_op(8'hFF, 8'hFF, 1'b1, 5);
        run_op(8'h7F, 8'h01, 1'b0, 1);
        run_op(8'h80, 8'h80, 1'b0, 2);
        run_op(8'h00, 8'h00, 1'b0, 0);

        // Reset asserted in the 4th SHIFT cycle aborts the operation.
        @(negedge clk);
        a_in = 8'h55; b_in = 8'h33; c_in = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        last_sum = '0; last_cout = 1'b0; last_ovf = 1'b0;
        check_val("abort_in_ready", 32'(in_ready), 32'd1);
        check_val("abort_out_valid", 32'(out_valid), 32'd0);
        check_held("abort");
        saw_valid = 1'b0;
        for (int i = 0; i < W + 4; i++) begin
            @(posedge clk); #1;
            saw_valid = saw_valid | out_valid;
        end
        check_val("abort_no_valid", 32'(saw_valid), 32'd0);
        run_op(8'h03, 8'h04, 1'b0, 0);

        for (int i = 0; i < 12; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(3)));
        end

        // Back-to-back: in_valid and out_ready held high, operands change every cycle.
        prev = -1; nres = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 90; i++) begin
            @(negedge clk);
            if (out_valid) begin
                if (q_sum.size() > 0) begin
                    check_val("b2b_sum", 32'(sum_out), 32'(q_sum[0]));
                    check_val("b2b_cout", 32'(c_out), 32'(q_cout[0]));
                    last_sum  = q_sum.pop_front();
                    last_cout = q_cout.pop_front();
                end else begin
                    check_val("b2b_unexpected_result", 32'd1, 32'd0);
                end
                if (prev >= 0) begin
                    check_val("b2b_period", 32'(i - prev), 32'(W + 2));
                end
                prev = i;
                nres++;
            end
            if (i < 62) begin
                ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
                a_in = ra; b_in = rb; c_in = rc; in_valid = 1'b1;
                if (in_ready) begin
                    full = ref_add(ra, rb, rc);
                    q_sum.push_back(full[W-1:0]);
                    q_cout.push_back(full[W]);
                end
            end else begin
                in_valid = 1'b0;
            end
        end
        check_val("b2b_drained", 32'(q_sum.size()), 32'd0);
        check_val("b2b_count", 32'(nres), 32'd7);
        out_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving operand and result width in bits; legal range 2..32.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  operand set presented.
REQ-005 SHALL have port in_ready  output  1  block can accept an operand set.
REQ-006 SHALL have ports a_in, b_in  input  WIDTH  addend operands, unsigned or two's complement.
REQ-007 SHALL have port c_in  input  1  carry-in for bit 0.
REQ-008 SHALL have port out_valid  output  1  result held and valid.
REQ-009 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-010 SHALL have port sum_out  output  WIDTH  registered sum.
REQ-011 SHALL have port c_out  output  1  registered carry out of bit WIDTH-1.

Function
REQ-012 SHALL implement three states: IDLE, SHIFT, DONE.
REQ-013 SHALL assert in_ready only in IDLE; outputs SHALL be registered or decoded from state only, never combinationally from inputs.
REQ-014 SHALL, on an edge with in_valid && in_ready, capture a_in, b_in and c_in into internal registers, clear the bit counter, and enter SHIFT; inputs outside an accepting edge SHALL be ignored.
REQ-015 SHALL, in SHIFT, add one bit per cycle, LSB first: bit i of the sum = a[i]^b[i]^carry; carry register updated to the majority of a[i], b[i] and carry.
REQ-016 SHALL use a bit counter of width $clog2(WIDTH) and leave SHIFT for DONE on the edge that processes bit WIDTH-1.
REQ-017 SHALL raise out_valid exactly WIDTH rising edges after the accepting edge.
REQ-018 SHALL, in DONE, hold sum_out, c_out and out_valid stable until an edge with out_ready=1, then return to IDLE with out_valid low.
REQ-019 SHALL NOT bypass DONE to accept a new operand set: in_ready rises in the cycle after the result handshake, so the minimum period is WIDTH+2 cycles per operation.
REQ-020 SHALL ignore out_ready outside DONE and in_valid outside IDLE.
REQ-021 SHALL produce a modulo-2^WIDTH sum with c_out = bit WIDTH of a+b+c_in, including the all-ones wrap-around case.
REQ-022 SHALL leave sum_out and c_out unchanged from the previous result while in IDLE and SHIFT; they update only on the edge entering DONE.

Reset
REQ-023 SHALL, with reset high at an edge, force state IDLE, counter 0, carry 0, sum_out 0, c_out 0 and out_valid 0; in_ready SHALL then be 1.
REQ-024 SHALL, on reset asserted in SHIFT or DONE, abort and discard the operation with no out_valid pulse.
REQ-025 SHALL give reset priority over every handshake on the same edge.

Configuration
REQ-026 SHALL, when SERIAL_ADDER_OVF_EN is defined, add output ovf_out  1, meaning signed overflow = carry into bit WIDTH-1 XOR c_out.
REQ-027 SHALL give ovf_out the same registering, update and reset rules as c_out.
REQ-028 SHALL, without SERIAL_ADDER_OVF_EN, have neither the ovf_out port nor its logic.

Structure
REQ-029 SHALL take the state encoding typedef (IDLE/SHIFT/DONE) and the default WIDTH constant from shared package serial_adder_pkg.
REQ-030 SHALL instantiate one combinational 1-bit full-adder sub-module, fa_cell (a, b, ci -> s, co), for the per-bit add; all sequencing SHALL remain in serial_adder.

Verification
REQ-031 SHALL cover: WIDTH=8, a=0x0F, b=0x01, c_in=0 -> sum_out=0x10, c_out=0, out_valid 8 edges after accept.
REQ-032 SHALL cover: a=0xFF, b=0x01, c_in=0 -> sum_out=0x00, c_out=1; and a=0xFF, b=0xFF, c_in=1 -> sum_out=0xFF, c_out=1.
REQ-033 SHALL cover: out_ready held low 5 cycles in DONE -> sum_out, c_out and out_valid stable, in_ready 0; out_ready high -> IDLE next edge.
REQ-034 SHALL cover: reset pulsed on the 4th SHIFT cycle -> IDLE, all outputs 0, no out_valid; next operation 0x03+0x04 -> 0x07.
REQ-035 SHALL cover: back-to-back in_valid with out_ready tied high -> one result every 10 cycles, in_valid ignored while in_ready=0.
REQ-036 SHALL cover, with SERIAL_ADDER_OVF_EN: a=0x7F, b=0x01 -> sum_out=0x80, ovf_out=1, c_out=0; a=0xFF, b=0x01 -> ovf_out=0.
